button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 247 ++++++++++++++++++++++++
 tb/tb_button_debouncer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Debounces the two ship-control push buttons (left / right). Each channel
// synchronises its raw pin, runs a four-state debounce FSM and produces:
//   - a registered one-cycle move pulse on every accepted press, and
//   - a registered held level while the press is accepted.
// The two channels are identical instances with no shared state. When both
// buttons are accepted in the same cycle, both pulses are asserted. Choosing
// between them is left to the ship position stage.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN):
//   When defined, a held button also emits repeat pulses. The first repeat
//   comes REPEAT_DELAY cycles after the press pulse. Later repeats come every
//   REPEAT_PERIOD cycles. When undefined, every accepted press gives exactly
//   one pulse and no repeat hardware is built.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press/release (2..2^20-1)
//   REPEAT_DELAY     press pulse -> first repeat pulse (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD    spacing of later repeat pulses (AUTO_REPEAT_EN only)
//
// Ports:
//   i_clk_36MHz        sole clock, rising edge
//   i_reset            synchronous reset, active-high
//   i_left_raw         raw left button pin (asynchronous, may bounce)
//   i_right_raw        raw right button pin (asynchronous, may bounce)
//   o_left_debounced   one-cycle move pulse, left
//   o_right_debounced  one-cycle move pulse, right
//   o_left_level       debounced held level, left
//   o_right_level      debounced held level, right
// -----------------------------------------------------------------------------

module button_debouncer_channel #(
    parameter int DEBOUNCE_CYCLES = 360000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 10800000,
    parameter int REPEAT_PERIOD   = 3600000
`endif
) (
    input  logic i_clk_36MHz,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

    logic        sync_meta_r;
    logic        sync_r;
    state_t      state_r;
    logic [31:0] cnt_r;
    logic        pulse_r;
    logic        level_r;

`ifdef AUTO_REPEAT_EN
    localparam logic [31:0] REP_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] REP_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rep_cnt_r;
    logic        rep_first_r;   // still waiting for the first (long) repeat interval
    logic [31:0] rep_last_s;
    logic        rep_fire_s;

    // Select the current repeat interval and flag its last cycle.
    always_comb begin
        rep_last_s = REP_PERIOD_LAST;
        if (rep_first_r) begin
            rep_last_s = REP_DELAY_LAST;
        end else begin
            rep_last_s = REP_PERIOD_LAST;
        end
        rep_fire_s = (rep_cnt_r == rep_last_s);
    end
`endif

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= i_raw;
            sync_r      <= sync_meta_r;
        end
    end

    // Debounce FSM with registered pulse and level outputs.
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            state_r     <= IDLE;
            cnt_r       <= 32'd0;
            pulse_r     <= 1'b0;
            level_r     <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_r   <= 32'd0;
            rep_first_r <= 1'b1;
`endif
        end else begin
            pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    level_r <= 1'b0;
                    cnt_r   <= 32'd0;
                    if (sync_r) begin
                        state_r <= PRESS_WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_r) begin
                        state_r <= IDLE;
                        cnt_r   <= 32'd0;
                        level_r <= 1'b0;
                    end else if (cnt_r == DB_LAST) begin
                        // Press accepted: the pulse and level rise on the same edge.
                        state_r     <= HELD;
                        cnt_r       <= 32'd0;
                        pulse_r     <= 1'b1;
                        level_r     <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_r   <= 32'd0;
                        rep_first_r <= 1'b1;
`endif
                    end else begin
                        cnt_r   <= cnt_r + 32'd1;
                        level_r <= 1'b0;
                    end
                end
                HELD: begin
                    level_r <= 1'b1;
                    if (!sync_r) begin
                        state_r <= RELEASE_WAIT;
                        cnt_r   <= 32'd0;
                    end else begin
                        state_r <= HELD;
                        cnt_r   <= 32'd0;
`ifdef AUTO_REPEAT_EN
                        if (rep_fire_s) begin
                            pulse_r     <= 1'b1;
                            rep_cnt_r   <= 32'd0;
                            rep_first_r <= 1'b0;
                        end else begin
                            rep_cnt_r   <= rep_cnt_r + 32'd1;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_r) begin
                        // A bounce back to high resumes HELD without a new press pulse.
                        state_r     <= HELD;
                        cnt_r       <= 32'd0;
                        level_r     <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_r   <= 32'd0;
                        rep_first_r <= 1'b0;
`endif
                    end else if (cnt_r == DB_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= 32'd0;
                        level_r <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 32'd1;
                        level_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 32'd0;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse = pulse_r;
    assign o_level = level_r;

endmodule

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 360000,
    parameter int REPEAT_DELAY    = 10800000,
    parameter int REPEAT_PERIOD   = 3600000
) (
    input  logic i_clk_36MHz,
    input  logic i_reset,
    input  logic i_left_raw,
    input  logic i_right_raw,
    output logic o_left_debounced,
    output logic o_right_debounced,
    output logic o_left_level,
    output logic o_right_level
);

    // Reject illegal parameter values when the design is elaborated.
    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
            $error("button_debouncer: DEBOUNCE_CYCLES out of range 2..2^20-1");
        end
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
            $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
        end
    endgenerate

    button_debouncer_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_left (
        .i_clk_36MHz (i_clk_36MHz),
        .i_reset     (i_reset),
        .i_raw       (i_left_raw),
        .o_pulse     (o_left_debounced),
        .o_level     (o_left_level)
    );

    button_debouncer_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_right (
        .i_clk_36MHz (i_clk_36MHz),
        .i_reset     (i_reset),
        .i_raw       (i_right_raw),
        .o_pulse     (o_right_debounced),
        .o_level     (o_right_level)
    );

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer -- directed self-checking bench for button_debouncer
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Outputs are sampled 1 time unit after each rising edge. obs packs them as
// {left pulse, left level, right pulse, right level}.
// -----------------------------------------------------------------------------

module tb_button_debouncer;

    logic i_clk_36MHz = 1'b0;
    logic i_reset;
    logic i_left_raw;
    logic i_right_raw;
    logic o_left_debounced;
    logic o_right_debounced;
    logic o_left_level;
    logic o_right_level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] obs;
    assign obs = {o_left_debounced, o_left_level, o_right_debounced, o_right_level};

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .i_clk_36MHz       (i_clk_36MHz),
        .i_reset           (i_reset),
        .i_left_raw        (i_left_raw),
        .i_right_raw       (i_right_raw),
        .o_left_debounced  (o_left_debounced),
        .o_right_debounced (o_right_debounced),
        .o_left_level      (o_left_level),
        .o_right_level     (o_right_level)
    );

    always #5 i_clk_36MHz = ~i_clk_36MHz;

    task automatic tick();
        @(posedge i_clk_36MHz);
        #1;
    endtask

    task automatic test_reset();
        i_reset     = 1'b1;
        i_left_raw  = 1'b0;
        i_right_raw = 1'b0;
        for (int i = 1; i <= 3; i++) tick();
        n_tests++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%b expected %b", obs, 4'b0000);
        end
        i_reset = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            n_tests++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: outputs=%b expected %b", i, obs, 4'b0000);
            end
        end
    endtask

    task automatic test_left_press();
        logic [3:0] exp;
        i_left_raw = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp = {(i == 7), (i >= 7), 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL left_press cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
        i_left_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = {1'b0, (i < 7), 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL left_release cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_right_glitch();
        int c;
        c = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) begin
                i_right_raw = (i < 3) ? 1'b1 : 1'b0;
                tick();
                c++;
                n_tests++;
                if (obs !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL right_glitch cyc %0d: outputs=%b expected %b", c, obs, 4'b0000);
                end
            end
        end
        i_right_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL right_glitch_tail cyc %0d: outputs=%b expected %b", i, obs, 4'b0000);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp;
        i_left_raw  = 1'b1;
        i_right_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = {(i == 7), (i >= 7), (i == 7), (i >= 7)};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL both_press cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
        // Release bounce: low, high, then low for good (final low at cycle 3).
        for (int i = 1; i <= 14; i++) begin
            i_left_raw  = (i == 2) ? 1'b1 : 1'b0;
            i_right_raw = (i == 2) ? 1'b1 : 1'b0;
            tick();
            exp = {1'b0, (i < 9), 1'b0, (i < 9)};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL both_release cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] exp;
        i_left_raw = 1'b1;
        // After 5 edges the left FSM is in PRESS_WAIT with counter 2.
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_tests++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: outputs=%b expected %b", i, obs, 4'b0000);
            end
        end
        i_reset = 1'b1;
        tick();
        n_tests++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: outputs=%b expected %b", obs, 4'b0000);
        end
        i_reset = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            exp = {(j == 7), (j >= 7), 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL post_reset_press cyc %0d: outputs=%b expected %b", j, obs, exp);
            end
        end
        i_left_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = {1'b0, (i < 7), 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL post_reset_release cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [3:0] exp;
        logic       rep;
        i_left_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            rep = (i >= 17) && (((i - 17) % 3) == 0);
`else
            rep = 1'b0;
`endif
            exp = {((i == 7) || rep), (i >= 7), 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold_repeat cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
        i_left_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            // Still HELD on the first release edge, which is also a repeat slot.
            rep = (i == 1);
`else
            rep = 1'b0;
`endif
            exp = {rep, (i < 7), 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL repeat_release cyc %0d: outputs=%b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        i_reset     = 1'b1;
        i_left_raw  = 1'b0;
        i_right_raw = 1'b0;
        test_reset();
        test_left_press();
        test_right_glitch();
        test_simultaneous();
        test_reset_mid_debounce();
        test_auto_repeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
